// File: rtl/mem_bus_pkg.sv
// Shared memory-bus types for the master arbiter.
// Grant index width helper keeps a one-bit floor for two masters.
package mem_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int grant_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mem_arbiter_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr,
// wrapping at the top.
module rr_pick
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  localparam int GW = grant_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GW-1:0]          rr_ptr,
  output logic [GW-1:0]          winner,
  output logic                   any_valid
);

  logic [GW:0]   sum;
  logic [GW-1:0] idx;

  // Scan from farthest to nearest so the nearest requester wins last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (GW + 1)'(k);
      if (sum >= (GW + 1)'(NUM_MASTERS))
        sum = sum - (GW + 1)'(NUM_MASTERS);
      idx = sum[GW-1:0];
      if (req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between several masters,
// with a per-transaction timeout that turns a hung slave into a fault.
module rr_mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [32*NUM_MASTERS-1:0] m_address_in,
  input  logic [NUM_MASTERS-1:0]    m_read_in,
  input  logic [NUM_MASTERS-1:0]    m_write_in,
  input  logic [4*NUM_MASTERS-1:0]  m_write_mask_in,
  input  logic [32*NUM_MASTERS-1:0] m_write_value_in,
  output logic [32*NUM_MASTERS-1:0] m_read_value_out,
  output logic [NUM_MASTERS-1:0]    m_ready_out,
  output logic [NUM_MASTERS-1:0]    m_fault_out,
  output logic [31:0]               address_out,
  output logic                      read_out,
  output logic                      write_out,
  output logic [3:0]                write_mask_out,
  output logic [31:0]               write_value_out,
  input  logic [31:0]               read_value_in,
  input  logic                      ready_in,
  input  logic                      fault_in
);

  localparam int GRANT_WIDTH = grant_width(NUM_MASTERS);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t               state_q, state_d;
  logic [GRANT_WIDTH-1:0]   grant_q, grant_d;
  logic [GRANT_WIDTH-1:0]   ptr_q, ptr_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0]   req;
  logic [GRANT_WIDTH-1:0]   winner;
  logic                     any_valid;
  logic [GRANT_WIDTH-1:0]   ptr_next;
  logic                     timed_out;
  int                       gi;

  assign req = m_read_in | m_write_in;
  assign gi  = int'(grant_q);
  assign ptr_next = (grant_q == GRANT_WIDTH'(NUM_MASTERS - 1)) ?
                    '0 : grant_q + 1'b1;
  assign timed_out = !ready_in && (cnt_q == TO_LAST);

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req      (req),
    .rr_ptr   (ptr_q),
    .winner   (winner),
    .any_valid(any_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    ptr_d            = ptr_q;
    cnt_d            = cnt_q;
    address_out      = '0;
    read_out         = 1'b0;
    write_out        = 1'b0;
    write_mask_out   = '0;
    write_value_out  = '0;
    m_read_value_out = '0;
    m_ready_out      = '0;
    m_fault_out      = '0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // A timed-out cycle drives nothing onto the bus.
        if (!timed_out) begin
          address_out     = m_address_in[gi*32 +: 32];
          read_out        = m_read_in[grant_q];
          write_out       = m_write_in[grant_q];
          write_mask_out  = m_write_mask_in[gi*4 +: 4];
          write_value_out = m_write_value_in[gi*32 +: 32];
          m_read_value_out[gi*32 +: 32] = read_value_in;
        end
        if (!req[grant_q]) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end else if (ready_in) begin
          m_ready_out[grant_q] = 1'b1;
          m_fault_out[grant_q] = fault_in;
          state_d = IDLE;
          ptr_d   = ptr_next;
        end else if (timed_out) begin
          m_ready_out[grant_q] = 1'b1;
          m_fault_out[grant_q] = 1'b1;
          state_d = IDLE;
          ptr_d   = ptr_next;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Self-checking bench for rr_mem_arbiter: vector table for single-master
// transactions plus hand sequences for timeout, fairness, abort and reset.
module tb_rr_mem_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [95:0]   m_address_in;
  logic [2:0]    m_read_in;
  logic [2:0]    m_write_in;
  logic [11:0]   m_write_mask_in;
  logic [95:0]   m_write_value_in;
  logic [95:0]   m_read_value_out;
  logic [2:0]    m_ready_out;
  logic [2:0]    m_fault_out;
  logic [31:0]   address_out;
  logic          read_out;
  logic          write_out;
  logic [3:0]    write_mask_out;
  logic [31:0]   write_value_out;
  logic [31:0]   read_value_in;
  logic          ready_in;
  logic          fault_in;

  rr_mem_arbiter #(
    .NUM_MASTERS   (N),
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_WIDTH (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m_address_in    (m_address_in),
    .m_read_in       (m_read_in),
    .m_write_in      (m_write_in),
    .m_write_mask_in (m_write_mask_in),
    .m_write_value_in(m_write_value_in),
    .m_read_value_out(m_read_value_out),
    .m_ready_out     (m_ready_out),
    .m_fault_out     (m_fault_out),
    .address_out     (address_out),
    .read_out        (read_out),
    .write_out       (write_out),
    .write_mask_out  (write_mask_out),
    .write_value_out (write_value_out),
    .read_value_in   (read_value_in),
    .ready_in        (ready_in),
    .fault_in        (fault_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          master;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          flt;
    int          delay;
  } vec_t;

  typedef struct {
    logic [2:0]  rdy;
    logic [2:0]  flt;
    logic [95:0] rval;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   gq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic clear_masters();
    m_address_in     = '0;
    m_read_in        = '0;
    m_write_in       = '0;
    m_write_mask_in  = '0;
    m_write_value_in = '0;
    ready_in         = 1'b0;
    fault_in         = 1'b0;
    read_value_in    = '0;
  endtask

  task automatic all_request();
    for (int i = 0; i < N; i++) begin
      m_address_in[32*i +: 32] = 32'h0000_1000 + 32'(i * 16);
      m_read_in[i] = 1'b1;
    end
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    step();
    clear_masters();
    m_address_in[32*v.master +: 32]     = v.addr;
    m_read_in[v.master]                 = !v.wr;
    m_write_in[v.master]                = v.wr;
    m_write_mask_in[4*v.master +: 4]    = v.mask;
    m_write_value_in[32*v.master +: 32] = v.wdata;
    e.rdy  = 3'b001 << v.master;
    e.flt  = v.flt ? e.rdy : 3'b000;
    e.rval = '0;
    e.rval[32*v.master +: 32] = v.rdata;
    sb.push_back(e);
    samp();
    chk("idle_bus", {address_out, read_out, write_out}, '0);
    chk("idle_ready", m_ready_out, '0);
    for (int d = 0; d <= v.delay; d++) begin
      step();
      ready_in      = (d == v.delay);
      fault_in      = (d == v.delay) && v.flt;
      read_value_in = v.rdata;
      samp();
      chk("bus_addr", address_out, v.addr);
      chk("bus_rw", {read_out, write_out}, {!v.wr, v.wr});
      chk("bus_mask", write_mask_out, v.mask);
      chk("bus_wdata", write_value_out, v.wdata);
      if (d == v.delay) begin
        e = sb.pop_front();
        chk("txn_ready", m_ready_out, e.rdy);
        chk("txn_fault", m_fault_out, e.flt);
        chk("txn_rdata", m_read_value_out, e.rval);
      end else begin
        chk("wait_ready", m_ready_out, '0);
      end
    end
    step();
    clear_masters();
    samp();
    chk("post_idle", {read_out, write_out, m_ready_out}, '0);
  endtask

  // Masters already requesting; expected grant order is in gq.
  task automatic run_grants();
    int k;
    int m;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      samp();
      if (m_ready_out != 3'b000) begin
        m = gq.pop_front();
        chk("grant_order", m_ready_out, 3'b001 << m);
        chk("grant_cycle", c, 2 * k + 1);
        k++;
        if (gq.size() == 0) break;
      end
      step();
    end
    if (gq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout: got %0d pending expected 0", gq.size());
      gq.delete();
    end
  endtask

  initial begin
    vecs[0] = '{1, 1'b0, 32'h1000_0004, 4'hF, 32'h0,
                32'hDEAD_BEEF, 1'b0, 0};
    vecs[1] = '{2, 1'b1, 32'h0001_0000, 4'b0011, 32'h1234_5678,
                32'h0, 1'b0, 0};
    vecs[2] = '{0, 1'b0, 32'h0000_0100, 4'hF, 32'h0,
                32'hA5A5_0001, 1'b0, 2};
    vecs[3] = '{2, 1'b1, 32'h4000_0008, 4'b0000, 32'hCAFE_F00D,
                32'h0, 1'b0, 1};
    vecs[4] = '{1, 1'b0, 32'h2000_0000, 4'hF, 32'h0,
                32'h0, 1'b1, 0};

    reset = 1'b1;
    clear_masters();
    step();
    step();
    samp();
    chk("rst_bus", {address_out, read_out, write_out,
                    write_mask_out, write_value_out}, '0);
    chk("rst_m", {m_ready_out, m_fault_out, m_read_value_out}, '0);
    step();
    reset = 1'b0;

    // Slave response while idle is ignored.
    ready_in = 1'b1;
    fault_in = 1'b1;
    read_value_in = 32'hFFFF_FFFF;
    samp();
    chk("idle_ign_rdy", {m_ready_out, m_fault_out}, '0);
    chk("idle_ign_rval", m_read_value_out, '0);
    step();
    clear_masters();

    // Timeout: master 0, slave never ready, fault on 4th busy cycle.
    m_address_in[31:0] = 32'h0000_0300;
    m_read_in[0] = 1'b1;
    samp();
    for (int b = 1; b <= 4; b++) begin
      step();
      samp();
      if (b < 4) begin
        chk("to_wait", {m_ready_out, m_fault_out}, '0);
        chk("to_addr", address_out, 32'h0000_0300);
      end else begin
        chk("to_ready", m_ready_out, 3'b001);
        chk("to_fault", m_fault_out, 3'b001);
        chk("to_bus", {address_out, read_out, write_out}, '0);
      end
    end
    step();
    clear_masters();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Faulted master 1 leaves rr_ptr at 2.
    step();
    ready_in = 1'b1;
    all_request();
    gq = '{2, 0, 1, 2};
    run_grants();
    step();
    clear_masters();

    // Abort: master 0 drops its request mid-transaction.
    step();
    m_read_in[0] = 1'b1;
    samp();
    step();
    m_read_in[0] = 1'b0;
    samp();
    chk("abort_noready", m_ready_out, '0);
    step();
    ready_in = 1'b1;
    all_request();
    gq = '{1};
    run_grants();
    step();
    clear_masters();

    // Reset mid-busy clears outputs without a clock edge.
    step();
    m_address_in[63:32] = 32'h0000_0044;
    m_read_in[1] = 1'b1;
    samp();
    step();
    samp();
    chk("pre_rst_addr", address_out, 32'h0000_0044);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_bus", {address_out, read_out, write_out}, '0);
    chk("rst_async_m", {m_ready_out, m_fault_out, m_read_value_out}, '0);
    step();
    step();
    reset = 1'b0;
    clear_masters();
    ready_in = 1'b1;
    all_request();
    gq = '{0, 1, 2, 0};
    run_grants();
    step();
    clear_masters();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mem_arbiter.md
Name: rr_mem_arbiter

Overview:
- N-master round-robin arbiter for the shared memory bus (address/read/write/mask/value, ready/fault), in front of the slave address decoder.
- Lets the CPU port plus additional masters (DMA, debug) share RAM, flash, UART, timer and LEDs fairly.
- Adds a per-transaction timeout that converts a hung slave into a bus fault.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 255, busy cycles without ready_in before a forced fault (1..2^TIMEOUT_WIDTH-1).
- TIMEOUT_WIDTH, 8, width of the timeout counter.

Ports:
- clk  in  1  system clock (pll_clk domain)
- reset  in  1  asynchronous, active-high reset
- m_address_in  in  32*NUM_MASTERS  per-master address, master i at bits [32i+31:32i]
- m_read_in  in  NUM_MASTERS  per-master read request
- m_write_in  in  NUM_MASTERS  per-master write request
- m_write_mask_in  in  4*NUM_MASTERS  per-master byte write mask
- m_write_value_in  in  32*NUM_MASTERS  per-master write data
- m_read_value_out  out  32*NUM_MASTERS  read data; nonzero only on the granted master's slice
- m_ready_out  out  NUM_MASTERS  transaction complete, one-hot or zero
- m_fault_out  out  NUM_MASTERS  transaction faulted; only asserted together with m_ready_out
- address_out  out  32  shared bus address
- read_out  out  1  shared bus read
- write_out  out  1  shared bus write
- write_mask_out  out  4  shared bus byte mask
- write_value_out  out  32  shared bus write data
- read_value_in  in  32  OR-combined slave read data
- ready_in  in  1  slave ready (may be combinational in the same cycle)
- fault_in  in  1  decoder fault (unmapped address)

Behaviour:
- Reset (async) values:
  - state=IDLE, grant=0, rr_ptr=0, timeout count=0.
  - All bus outputs 0; all m_ready_out, m_fault_out and m_read_value_out 0.
- Request: master i requests when m_read_in[i] | m_write_in[i]. The master holds all its signals stable until its m_ready_out.
- IDLE:
  - If any request is pending, pick the first requester searching upward from rr_ptr, wrapping at NUM_MASTERS-1 to 0.
  - Register it as grant, go to BUSY, clear the counter.
  - Bus outputs stay 0 in IDLE, giving 1 cycle of arbitration latency.
- BUSY:
  - Bus outputs combinationally mirror the granted master's inputs.
  - read_value_in is routed only to that master's slice.
  - Completion when ready_in=1:
    - m_ready_out[grant]=1 and m_fault_out[grant]=fault_in, in the same cycle.
    - Next state IDLE; rr_ptr = grant+1 mod NUM_MASTERS.
  - Timeout when ready_in=0 and the counter equals TIMEOUT_CYCLES-1:
    - m_ready_out[grant]=1 and m_fault_out[grant]=1 that cycle.
    - Bus outputs are forced to 0 that cycle; next IDLE; rr_ptr advances.
  - Otherwise the counter increments; it saturates and never wraps.
  - Abort: if the granted master deasserts both read and write while BUSY, go to IDLE. No ready is given and rr_ptr advances.
- Minimum throughput: one transaction every 2 cycles (IDLE+BUSY with a same-cycle slave ready). A single master streaming back-to-back therefore sees a 1-cycle gap.
- Fairness: with all masters requesting continuously, the grant order is 0,1,..,N-1,0,..; no master waits more than N-1 transactions.
- A new request arriving while BUSY is only considered at the next IDLE.
- ready_in and fault_in seen in IDLE are ignored and produce no master response.
- Read data is combinational passthrough, never registered.
- A write with write_mask 0 is passed through unchanged; the arbiter does not interpret the mask.

Decomposition:
- Shared package mem_bus_pkg holds:
  - typedef arb_state_t {IDLE, BUSY};
  - localparam GRANT_WIDTH = $clog2(NUM_MASTERS), with a floor of 1.
- One sub-module rr_pick: purely combinational. Inputs are the request vector and rr_ptr; outputs are the winner index and an any_valid flag. Unit-testable alone.

Test Plan:
- Master 1 alone reads 0x10000004, slave ready the next cycle with 0xDEADBEEF:
  - bus address 0x10000004 in cycle 2.
  - m_ready_out=3'b010, m_read_value_out slice 1 = 0xDEADBEEF, other slices 0.
- Masters 0, 1 and 2 request simultaneously and continuously, ready_in tied 1:
  - grants in order 0,1,2,0, one completion every 2 cycles.
- Master 2 writes mask 4'b0011 value 0x12345678 to 0x00010000 with same-cycle ready:
  - bus write_out=1, write_mask_out=4'b0011, write_value_out=0x12345678 for exactly 1 cycle.
- Master 0 reads with ready_in held 0 and TIMEOUT_CYCLES=4:
  - m_ready_out[0] and m_fault_out[0] assert together in the 4th BUSY cycle.
  - Bus outputs 0 in that cycle.
- Master 1 reads 0x20000000 with decoder fault_in=1 and ready_in=1:
  - m_fault_out[1]=1 with m_ready_out[1]=1 in that cycle; rr_ptr becomes 2.
- reset asserted mid-BUSY:
  - All outputs 0 immediately, without waiting for a clock.
  - After release, master 0 is granted first when all masters request.
